// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache with a single
// outstanding refill and forwarding of the refill word to IF.
module inst_cache #(
    parameter int INDEX_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        IF_inst_read_valid,
    input  logic [31:0] IF_inst_addr,
    output logic        IF_inst_valid,
    output logic [31:0] IF_inst,
    output logic        MemCtrl_inst_read_valid,
    output logic [31:0] MemCtrl_inst_addr,
    input  logic        MemCtrl_inst_valid,
    input  logic [31:0] MemCtrl_inst
);
    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = 30 - INDEX_WIDTH;

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_MEM = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             if_vld_q, if_vld_d;
    logic [31:0]      if_inst_q, if_inst_d;
    logic             mem_rd_q, mem_rd_d;
    // The refill address doubles as the latched miss address for the
    // whole of WAIT_MEM, so no separate copy is kept.
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic             fill_we;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic [INDEX_WIDTH-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0]       req_tag, fill_tag;
    logic                   hit;

    assign req_idx  = IF_inst_addr[INDEX_WIDTH+1:2];
    assign req_tag  = IF_inst_addr[31:INDEX_WIDTH+2];
    assign fill_idx = mem_addr_q[INDEX_WIDTH+1:2];
    assign fill_tag = mem_addr_q[31:INDEX_WIDTH+2];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign IF_inst_valid           = if_vld_q;
    assign IF_inst                 = if_inst_q;
    assign MemCtrl_inst_read_valid = mem_rd_q;
    assign MemCtrl_inst_addr       = mem_addr_q;

    // Lookup / miss / refill decision; IF response is a one-cycle pulse.
    always_comb begin
        state_d    = state_q;
        if_vld_d   = 1'b0;
        if_inst_d  = if_inst_q;
        mem_rd_d   = mem_rd_q;
        mem_addr_d = mem_addr_q;
        fill_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (IF_inst_read_valid) begin
                    if (hit) begin
                        if_vld_d  = 1'b1;
                        if_inst_d = data_q[req_idx];
                    end else begin
                        mem_addr_d = {IF_inst_addr[31:2], 2'b00};
                        mem_rd_d   = 1'b1;
                        state_d    = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                if (MemCtrl_inst_valid) begin
                    fill_we  = 1'b1;
                    mem_rd_d = 1'b0;
                    state_d  = IDLE;
                    // Only forward if IF still wants the word we fetched;
                    // after a jump the new address is looked up next cycle.
                    if (IF_inst_read_valid &&
                        IF_inst_addr[31:2] == mem_addr_q[31:2]) begin
                        if_vld_d  = 1'b1;
                        if_inst_d = MemCtrl_inst;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers; reset beats rdy, rdy=0 freezes all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            if_vld_q   <= 1'b0;
            if_inst_q  <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            if_vld_q   <= if_vld_d;
            if_inst_q  <= if_inst_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Line valid bits; reset invalidates the whole cache.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (rdy && fill_we) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag/data storage carries no reset; only a refill writes a line.
    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= MemCtrl_inst;
        end
    end
endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: cold miss, streaming hits, conflict,
// jump during refill, reset mid-refill and rdy stall.
module tb_inst_cache;
    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        if_rd;
    logic [31:0] if_addr;
    logic        if_vld;
    logic [31:0] if_inst;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_vld;
    logic [31:0] mem_data;

    int n_cmp = 0;
    int n_err = 0;

    inst_cache #(.INDEX_WIDTH(8)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .rdy                     (rdy),
        .IF_inst_read_valid      (if_rd),
        .IF_inst_addr            (if_addr),
        .IF_inst_valid           (if_vld),
        .IF_inst                 (if_inst),
        .MemCtrl_inst_read_valid (mem_rd),
        .MemCtrl_inst_addr       (mem_addr),
        .MemCtrl_inst_valid      (mem_vld),
        .MemCtrl_inst            (mem_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Observed state of all four outputs after an edge.
    task automatic chk_out(input string tag, input logic ev, input logic [31:0] ed,
                           input logic mr, input logic [31:0] ma);
        chk({tag, ".if_vld"}, {31'b0, if_vld}, {31'b0, ev});
        if (ev) chk({tag, ".if_inst"}, if_inst, ed);
        chk({tag, ".mem_rd"}, {31'b0, mem_rd}, {31'b0, mr});
        if (mr) chk({tag, ".mem_addr"}, mem_addr, ma);
    endtask

    // Miss on a, reply with d immediately, expect forwarding, then idle.
    task automatic fill(input logic [31:0] a, input logic [31:0] d);
        if_rd = 1'b1; if_addr = a;
        tick();
        chk_out("fill_miss", 1'b0, 32'h0, 1'b1, a);
        mem_vld = 1'b1; mem_data = d;
        tick();
        chk_out("fill_fwd", 1'b1, d, 1'b0, 32'h0);
        mem_vld = 1'b0; if_rd = 1'b0;
        tick();
        chk_out("fill_idle", 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; if_rd = 1'b0; if_addr = '0;
        mem_vld = 1'b0; mem_data = '0;
        tick(); tick();
        chk("rst.if_vld",   {31'b0, if_vld}, 32'h0);
        chk("rst.if_inst",  if_inst, 32'h0);
        chk("rst.mem_rd",   {31'b0, mem_rd}, 32'h0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        rst = 1'b0;

        // Cold miss with a 3-cycle reply, then re-read hits.
        if_rd = 1'b1; if_addr = 32'h0000_0002;
        tick();
        chk_out("cold_req", 1'b0, 32'h0, 1'b1, 32'h0);
        tick();
        chk_out("cold_w1", 1'b0, 32'h0, 1'b1, 32'h0);
        tick();
        chk_out("cold_w2", 1'b0, 32'h0, 1'b1, 32'h0);
        mem_vld = 1'b1; mem_data = 32'h0000_0013;
        tick();
        chk_out("cold_fwd", 1'b1, 32'h0000_0013, 1'b0, 32'h0);
        mem_vld = 1'b0;
        tick();
        chk_out("cold_hit", 1'b1, 32'h0000_0013, 1'b0, 32'h0);
        if_rd = 1'b0;
        tick();
        chk_out("idle_norq", 1'b0, 32'h0, 1'b0, 32'h0);

        // Streaming hits at one word per cycle.
        fill(32'h4, 32'hAAAA_0004);
        fill(32'h8, 32'hBBBB_0008);
        if_rd = 1'b1; if_addr = 32'h0;
        tick(); chk_out("str0", 1'b1, 32'h0000_0013, 1'b0, 32'h0);
        if_addr = 32'h4;
        tick(); chk_out("str1", 1'b1, 32'hAAAA_0004, 1'b0, 32'h0);
        if_addr = 32'h8;
        tick(); chk_out("str2", 1'b1, 32'hBBBB_0008, 1'b0, 32'h0);
        if_rd = 1'b0;
        tick(); chk_out("str_end", 1'b0, 32'h0, 1'b0, 32'h0);

        // Conflict: 0x400 evicts 0x0, so 0x0 misses again.
        fill(32'h400, 32'hCCCC_0400);
        fill(32'h0, 32'h0000_0013);

        // Jump during refill: 0x10 installed silently, 0x20 then misses.
        if_rd = 1'b1; if_addr = 32'h10;
        tick(); chk_out("jmp_miss", 1'b0, 32'h0, 1'b1, 32'h10);
        if_addr = 32'h20;
        tick(); chk_out("jmp_wait", 1'b0, 32'h0, 1'b1, 32'h10);
        mem_vld = 1'b1; mem_data = 32'hDDDD_0010;
        tick(); chk_out("jmp_fill", 1'b0, 32'h0, 1'b0, 32'h0);
        mem_vld = 1'b0;
        tick(); chk_out("jmp_miss2", 1'b0, 32'h0, 1'b1, 32'h20);
        mem_vld = 1'b1; mem_data = 32'hEEEE_0020;
        tick(); chk_out("jmp_fwd2", 1'b1, 32'hEEEE_0020, 1'b0, 32'h0);
        mem_vld = 1'b0; if_addr = 32'h10;
        tick(); chk_out("jmp_hit10", 1'b1, 32'hDDDD_0010, 1'b0, 32'h0);
        if_rd = 1'b0;
        tick();

        // Reset mid-refill; late reply in IDLE is ignored.
        if_rd = 1'b1; if_addr = 32'h30;
        tick(); chk_out("rr_miss", 1'b0, 32'h0, 1'b1, 32'h30);
        rst = 1'b1; if_rd = 1'b0;
        tick();
        chk_out("rr_rst", 1'b0, 32'h0, 1'b0, 32'h0);
        chk("rr_rst.mem_addr", mem_addr, 32'h0);
        rst = 1'b0; mem_vld = 1'b1; mem_data = 32'h0000_0099;
        tick(); chk_out("rr_late", 1'b0, 32'h0, 1'b0, 32'h0);
        mem_vld = 1'b0;
        fill(32'h30, 32'h3030_3030);
        // Reset also invalidated previously cached 0x4.
        fill(32'h4, 32'hAAAA_0004);

        // rdy stall during a hit response: everything freezes.
        if_rd = 1'b1; if_addr = 32'h30;
        tick(); chk_out("stall_hit", 1'b1, 32'h3030_3030, 1'b0, 32'h0);
        rdy = 1'b0; if_addr = 32'h8;
        for (int i = 0; i < 4; i++) begin
            mem_vld = (i == 1);
            tick(); chk_out("stall_hold", 1'b1, 32'h3030_3030, 1'b0, 32'h0);
        end
        mem_vld = 1'b0; rdy = 1'b1; if_addr = 32'h4;
        tick(); chk_out("stall_resume", 1'b1, 32'hAAAA_0004, 1'b0, 32'h0);
        if_addr = 32'h8;
        tick(); chk_out("stall_miss8", 1'b0, 32'h0, 1'b1, 32'h8);
        if_rd = 1'b0; mem_vld = 1'b1; mem_data = 32'hBBBB_0008;
        tick(); chk_out("stall_fill8", 1'b0, 32'h0, 1'b0, 32'h0);
        mem_vld = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
